button_debouncer: RTL and testbench
===================================

Name: button_debouncer

Overview:
Input-side front end for the board push-buttons and extra GPIO buttons that feed the 7-segment letter/digit logic.
- Synchronizes each raw button pin into the clock domain and applies polarity correction.
- Debounces each button with a per-button stability counter.
- Outputs clean levels plus one-cycle press/release pulses.
- Downstream segment encoders and counters consume these outputs instead of raw pins.

Parameters:
- N_BTN, 3, number of independent button inputs (e.g. BTN[1:0] plus pio[8]).
- DEBOUNCE_CYCLES, 50000, consecutive cycles the synchronized input must differ from the stable level before the stable level flips; legal range ≥ 1.
- ACTIVE_LOW, 0, when 1 a raw pin low means "pressed"; inversion is applied before the synchronizer.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- btn_raw, input, N_BTN, asynchronous raw button pins.
- btn_level, output, N_BTN, debounced pressed level (1 = pressed).
- btn_press, output, N_BTN, one-cycle pulse when btn_level[i] goes 0→1.
- btn_release, output, N_BTN, one-cycle pulse when btn_level[i] goes 1→0.
- any_press, output, 1, OR of btn_press.

Behaviour:
- One clock, clk. Reset is synchronous and active-high, sampled on the rising edge of clk. All state is per button i and independent.
- Polarity: p[i] = btn_raw[i] XOR ACTIVE_LOW.
- Synchronizer: two flops, s1 <= p and s2 <= s1. Value s = s2 lags the pin by 2 clocks.
- Counter cnt[i] has width clog2(DEBOUNCE_CYCLES), minimum 1 bit. Each edge, with no reset:
  - if s == stable: cnt <= 0.
  - else if cnt == DEBOUNCE_CYCLES-1: stable <= s, cnt <= 0; btn_press <= s, btn_release <= ~s.
  - else: cnt <= cnt+1.
- Pulses are deasserted (0) on every edge where the flip condition is not met, so each pulse is exactly 1 cycle wide.
- btn_level = stable, which is registered. btn_press and btn_release rise on the same edge that btn_level changes.
- any_press = |btn_press. It is combinational from registers.
- Latency: a clean pin transition is applied between edges 0 and 1. btn_level and the pulse change after edge 2+DEBOUNCE_CYCLES.
- Glitch rejection: any cycle with s == stable clears cnt. A bounce shorter than DEBOUNCE_CYCLES consecutive cycles produces no level change and no pulse.
- DEBOUNCE_CYCLES = 1: stable follows s with one extra cycle of delay, i.e. latency 3.
- Simultaneous events: buttons are fully independent. Several press and release pulses may assert in the same cycle. any_press asserts once for coincident presses.
- Reset values: s1, s2, stable, cnt, btn_level, btn_press, btn_release and any_press are all 0. A button held pressed through reset is therefore reported as a fresh press after 2+DEBOUNCE_CYCLES cycles from deassertion.
- Reset mid-count: the count is discarded and no pulse is emitted in the reset cycle or the cycle after.
- Counter wrap: cnt never exceeds DEBOUNCE_CYCLES-1, so there is no overflow.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, N_BTN=3, ACTIVE_LOW=0.
1. Clean press: btn_raw 000→001 between edges 0 and 1, held.
   - Required: btn_level=001 and btn_press=001 after edge 6 only; any_press=1 for that single cycle.
   - Release later gives the same latency, with btn_release=001 for 1 cycle.
2. Bounce: bit1 toggles 1,1,1,0,1,1,1,0 per cycle, then stays 0.
   - Required: btn_level[1] stays 0 and no pulse ever asserts.
3. Simultaneous: bits 0 and 2 rise in the same cycle.
   - Required: btn_press=101 in one cycle; any_press is high for exactly 1 cycle.
4. Reset mid-count: raise bit0, assert reset at the edge where cnt=2, then deassert with bit0 still high.
   - Required: all outputs 0 during reset; press pulse at 6 edges after the first non-reset edge.
5. ACTIVE_LOW=1: btn_raw idles at 111 after reset, then bit2 goes 0.
   - Required: no pulse after reset (level stays 000); btn_press=100 at the 6th edge after bit2 goes 0.
6. DEBOUNCE_CYCLES=1 build: single-cycle pin pulse.
   - Required: btn_level high exactly 1 cycle, followed by btn_release after latency 3.

Source files
------------

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : button_debouncer
//  Description : Front end for board push-buttons. Each raw pin is polarity
//                corrected, brought into the clk domain through a two-flop
//                synchronizer and debounced with its own stability counter.
//                Produces clean levels and one-cycle press/release pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             any_press
);

    // A single-cycle debounce still needs a 1-bit counter to exist.
    localparam int                 c_cnt_w   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] w_pol;
    logic [N_BTN-1:0] r_s1;
    logic [N_BTN-1:0] r_s2;

    // Inversion happens before the synchronizer so everything downstream
    // works in "1 = pressed" terms.
    assign w_pol = btn_raw ^ {N_BTN{ACTIVE_LOW}};

    // Two-flop synchronizer for all raw pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_pol;
            r_s2 <= r_s1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_btn
            logic [c_cnt_w-1:0] r_cnt;
            logic               r_stable;
            logic               r_press;
            logic               r_release;

            // Stability counter: any cycle that agrees with the stable level
            // restarts the count, so only an unbroken run flips the level.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt     <= '0;
                    r_stable  <= 1'b0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                end else begin
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                    if (r_s2[gi] == r_stable) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_cnt_max) begin
                        r_cnt     <= '0;
                        r_stable  <= r_s2[gi];
                        r_press   <= r_s2[gi];
                        r_release <= ~r_s2[gi];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign btn_level[gi]   = r_stable;
            assign btn_press[gi]   = r_press;
            assign btn_release[gi] = r_release;
        end
    endgenerate

    assign any_press = |btn_press;

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_debouncer
//  Description : Self-checking bench for button_debouncer. Three builds run
//                side by side (D=4 active-high, D=4 active-low, D=1) against
//                a sliding-window reference model, plus directed scenarios
//                with hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [2:0][2:0] raw;
    logic [2:0][2:0] lvl;
    logic [2:0][2:0] prs;
    logic [2:0][2:0] rel;
    logic [2:0]      anyp;

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  chk_en  = 1'b0;

    always #5 clk = ~clk;

    button_debouncer #(.N_BTN(3), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b0)) u_main (
        .clk(clk), .reset(reset), .btn_raw(raw[0]), .btn_level(lvl[0]),
        .btn_press(prs[0]), .btn_release(rel[0]), .any_press(anyp[0]));

    button_debouncer #(.N_BTN(3), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1)) u_alow (
        .clk(clk), .reset(reset), .btn_raw(raw[1]), .btn_level(lvl[1]),
        .btn_press(prs[1]), .btn_release(rel[1]), .any_press(anyp[1]));

    button_debouncer #(.N_BTN(3), .DEBOUNCE_CYCLES(1), .ACTIVE_LOW(1'b0)) u_d1 (
        .clk(clk), .reset(reset), .btn_raw(raw[2]), .btn_level(lvl[2]),
        .btn_press(prs[2]), .btn_release(rel[2]), .any_press(anyp[2]));

    function automatic int d_of(int i);
        return (i == 2) ? 1 : 4;
    endfunction

    function automatic bit al_of(int i);
        return (i == 1);
    endfunction

    task automatic check(string name, int inst, logic [2:0] got, logic [2:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d at %0t: got %b expected %b", name, inst, $time, got, exp);
        end
    endtask

    // Reference model: the level flips at an edge when the synchronized value
    // has disagreed with the level on each of the last D edges, with no flip
    // already inside that window.
    bit        m_s1     [3][3];
    bit        m_s2     [3][3];
    bit        m_stable [3][3];
    bit        m_press  [3][3];
    bit        m_rel    [3][3];
    bit [63:0] mm_h     [3][3];
    bit [63:0] fl_h     [3][3];

    // Model update on every rising edge.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            for (int b = 0; b < 3; b++) begin
                bit        p, s, mm, fl;
                bit [63:0] mask, win;
                p = raw[i][b] ^ al_of(i);
                if (reset) begin
                    m_s1[i][b] = 0; m_s2[i][b] = 0; m_stable[i][b] = 0;
                    m_press[i][b] = 0; m_rel[i][b] = 0;
                    mm_h[i][b] = '0; fl_h[i][b] = '0;
                end else begin
                    s    = m_s2[i][b];
                    mm   = (s != m_stable[i][b]);
                    mask = (64'd1 << d_of(i)) - 64'd1;
                    win  = {mm_h[i][b][62:0], mm};
                    fl   = ((win & mask) == mask) && ((fl_h[i][b] & (mask >> 1)) == 64'd0);
                    mm_h[i][b] = win;
                    fl_h[i][b] = {fl_h[i][b][62:0], fl};
                    m_press[i][b] = fl & s;
                    m_rel[i][b]   = fl & ~s;
                    if (fl) m_stable[i][b] = s;
                    m_s2[i][b] = m_s1[i][b];
                    m_s1[i][b] = p;
                end
            end
        end
    end

    // Compare every build against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                logic [2:0] el, ep, er;
                for (int b = 0; b < 3; b++) begin
                    el[b] = m_stable[i][b];
                    ep[b] = m_press[i][b];
                    er[b] = m_rel[i][b];
                end
                check("model_level",   i, lvl[i], el);
                check("model_press",   i, prs[i], ep);
                check("model_release", i, rel[i], er);
                check("model_any",     i, {2'b00, anyp[i]}, {2'b00, |ep});
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bit [7:0] seq;
        int       tprob;
        raw    = '0;
        raw[1] = 3'b111;
        reset  = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_level", 0, lvl[0], 3'b000);
        check("reset_press", 0, prs[0], 3'b000);
        check("reset_any",   0, {2'b00, anyp[0]}, 3'b000);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("alow_idle_level", 1, lvl[1], 3'b000);

        // Clean press and release.
        raw[0] = 3'b001;
        cyc(5);
        check("press_early_level", 0, lvl[0], 3'b000);
        cyc(1);
        check("press_level", 0, lvl[0], 3'b001);
        check("press_pulse", 0, prs[0], 3'b001);
        check("press_any",   0, {2'b00, anyp[0]}, 3'b001);
        cyc(1);
        check("press_pulse_end", 0, prs[0], 3'b000);
        check("press_any_end",   0, {2'b00, anyp[0]}, 3'b000);
        @(negedge clk);
        raw[0] = 3'b000;
        cyc(5);
        check("release_early_level", 0, lvl[0], 3'b001);
        cyc(1);
        check("release_level", 0, lvl[0], 3'b000);
        check("release_pulse", 0, rel[0], 3'b001);
        cyc(1);
        check("release_pulse_end", 0, rel[0], 3'b000);

        // Bounce shorter than the debounce window.
        seq = 8'b0111_0111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            raw[0][1] = seq[k];
        end
        @(negedge clk);
        raw[0][1] = 1'b0;
        repeat (10) @(negedge clk);
        check("bounce_level", 0, lvl[0], 3'b000);

        // Simultaneous presses.
        raw[0] = 3'b101;
        cyc(5);
        check("simul_any_early", 0, {2'b00, anyp[0]}, 3'b000);
        cyc(1);
        check("simul_press", 0, prs[0], 3'b101);
        check("simul_any",   0, {2'b00, anyp[0]}, 3'b001);
        cyc(1);
        check("simul_any_end", 0, {2'b00, anyp[0]}, 3'b000);
        @(negedge clk);
        raw[0] = 3'b000;
        repeat (10) @(negedge clk);

        // Reset while a press is being counted.
        raw[0] = 3'b001;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        cyc(1);
        check("rst_mid_level", 0, lvl[0], 3'b000);
        check("rst_mid_press", 0, prs[0], 3'b000);
        cyc(1);
        check("rst_mid_press2", 0, prs[0], 3'b000);
        @(negedge clk);
        reset = 1'b0;
        cyc(5);
        check("rst_after_early", 0, prs[0], 3'b000);
        cyc(1);
        check("rst_after_press", 0, prs[0], 3'b001);
        @(negedge clk);
        raw[0] = 3'b000;
        repeat (10) @(negedge clk);

        // Active-low build: bit2 pin goes low.
        check("alow_level_after_rst", 1, lvl[1], 3'b000);
        raw[1] = 3'b011;
        cyc(5);
        check("alow_press_early", 1, prs[1], 3'b000);
        cyc(1);
        check("alow_press", 1, prs[1], 3'b100);
        check("alow_level", 1, lvl[1], 3'b100);

        // D=1 build: one-cycle pin pulse.
        @(negedge clk);
        raw[2] = 3'b001;
        @(negedge clk);
        raw[2] = 3'b000;
        cyc(2);
        check("d1_level", 2, lvl[2], 3'b001);
        check("d1_press", 2, prs[2], 3'b001);
        cyc(1);
        check("d1_level_end", 2, lvl[2], 3'b000);
        check("d1_release",   2, rel[2], 3'b001);

        // Randomized traffic: alternating bouncy and calm phases, rare resets.
        tprob = 3;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ((c % 200) == 0) tprob = (tprob == 3) ? 12 : 3;
            for (int i = 0; i < 3; i++)
                for (int b = 0; b < 3; b++)
                    if ($urandom_range(0, tprob - 1) == 0) raw[i][b] = ~raw[i][b];
            reset = ($urandom_range(0, 399) == 0);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
